// File: rtl/conv3x3_gauss_stream.sv
// Streaming 3x3 Gaussian blur with two internal line buffers and a 2-stage valid/ready pipeline.
// Optional build macro CONV_ROUND_EN: each kernel term rounds half-up before its shift.
module conv3x3_gauss_stream #(
  parameter int unsigned DW    = 16,
  parameter int unsigned IMG_W = 512,
  parameter int unsigned IMG_H = 512,
  parameter int unsigned OW    = DW + 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_last,
  output logic          done
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic          adv;
  logic          accept;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic [DW-1:0] lb0_q [IMG_W];
  logic [DW-1:0] lb1_q [IMG_W];
  logic [DW-1:0] lb0_rd;
  logic [DW-1:0] lb1_rd;

  logic [DW-1:0] win_q [3][3];
  logic [DW-1:0] win_d [3][3];
  logic          s1_valid_q, s1_valid_d;
  logic          s1_last_q, s1_last_d;

  logic          out_valid_q, out_valid_d;
  logic [OW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          done_q, done_d;
  logic [OW-1:0] sum;

  // One kernel term: shift by s, optionally rounding half-up in DW+1 bits first.
  function automatic logic [OW-1:0] term(input logic [DW-1:0] p, input int unsigned s);
`ifdef CONV_ROUND_EN
    logic [DW:0] t;
    t = ({1'b0, p} + ((DW+1)'(1) << (s - 1))) >> s;
`else
    logic [DW-1:0] t;
    t = p >> s;
`endif
    return OW'(t);
  endfunction

  always_comb begin
    adv    = out_ready | ~out_valid_q;
    accept = in_valid & adv;
    lb0_rd = lb0_q[col_q];
    lb1_rd = lb1_q[col_q];
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Window column 2 is the newest; row 0 comes from the older line buffer.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 2; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = in_data;
    end
  end

  // S1 only moves when S2 can take its contents, so a stalled sink loses nothing.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    if (adv) begin
      s1_valid_d = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
      s1_last_d  = accept && (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
    end
  end

  always_comb begin
    sum = term(win_q[0][0], 4) + term(win_q[0][2], 4)
        + term(win_q[2][0], 4) + term(win_q[2][2], 4)
        + term(win_q[0][1], 3) + term(win_q[1][0], 3)
        + term(win_q[1][2], 3) + term(win_q[2][1], 3)
        + term(win_q[1][1], 2);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      out_data_d  = sum;
      out_last_d  = s1_valid_q & s1_last_q;
    end
    done_d = out_valid_q & out_ready & out_last_q;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_rd;
      lb0_q[col_q] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      win_q       <= win_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv3x3_gauss_stream.sv
// Directed bench for conv3x3_gauss_stream: frames driven in raster order, expected pixels queued
// from an image-level model and compared as the sink accepts them.
module tb_conv3x3_gauss_stream;

  localparam int unsigned DW    = 16;
  localparam int unsigned IMG_W = 8;
  localparam int unsigned IMG_H = 6;
  localparam int unsigned OW    = 19;
  localparam int unsigned NOUT  = (IMG_W - 2) * (IMG_H - 2);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          done;

  always #5 clk = ~clk;

  conv3x3_gauss_stream #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .OW(OW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .done(done)
  );

  typedef struct packed {
    logic [OW-1:0] d;
    logic          l;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned out_cnt = 0;
  int unsigned done_cnt = 0;
  bit          rand_rdy = 1'b0;
  bit          last_hs = 1'b0;
  logic [DW-1:0] img [IMG_H][IMG_W];

`ifdef CONV_ROUND_EN
  localparam int unsigned C15_EXP = 16;
`else
  localparam int unsigned C15_EXP = 7;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int unsigned tt(input int unsigned p, input int unsigned s);
`ifdef CONV_ROUND_EN
    return (p + (1 << (s - 1))) >> s;
`else
    return p >> s;
`endif
  endfunction

  function automatic int unsigned model(input int unsigned r, input int unsigned c);
    return tt(img[r-1][c-1], 4) + tt(img[r-1][c+1], 4) + tt(img[r+1][c-1], 4) + tt(img[r+1][c+1], 4)
         + tt(img[r-1][c], 3) + tt(img[r][c-1], 3) + tt(img[r][c+1], 3) + tt(img[r+1][c], 3)
         + tt(img[r][c], 2);
  endfunction

  task automatic load_const(input logic [DW-1:0] v);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) img[r][c] = v;
  endtask

  task automatic load_rand();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) img[r][c] = DW'($urandom);
  endtask

  task automatic push_model();
    exp_t e;
    for (int unsigned r = 1; r <= IMG_H - 2; r++)
      for (int unsigned c = 1; c <= IMG_W - 2; c++) begin
        e.d = OW'(model(r, c));
        e.l = (r == IMG_H - 2) && (c == IMG_W - 2);
        exp_q.push_back(e);
      end
  endtask

  task automatic push_const(input int unsigned v, input int unsigned n, input bit with_last);
    exp_t e;
    for (int unsigned i = 0; i < n; i++) begin
      e.d = OW'(v);
      e.l = with_last && (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_px(input logic [DW-1:0] p);
    int unsigned n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = p;
    #1;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 1000) chk("in_ready_timeout", in_ready, 1);
    @(posedge clk);
  endtask

  task automatic send_pixels(input int unsigned count);
    for (int unsigned i = 0; i < count; i++)
      send_px(img[i / IMG_W][i % IMG_W]);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_reset_state();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  // Sink side: drive out_ready, then judge the handshake that the next rising edge will complete.
  always @(negedge clk) begin
    out_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    #1;
    if (rst) begin
      last_hs = 1'b0;
    end else begin
      chk("done_pulse", done, last_hs);
      if (done === 1'b1) done_cnt++;
      last_hs = 1'b0;
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else if (out_ready) begin
          exp_t e;
          e = exp_q.pop_front();
          out_cnt++;
          chk("out_data", out_data, e.d);
          chk("out_last", out_last, e.l);
          last_hs = out_last;
        end else begin
          chk("stall_data", out_data, exp_q[0].d);
          chk("stall_last", out_last, exp_q[0].l);
        end
      end
    end
  end

  initial begin
    int unsigned d0;
    int unsigned o0;

    repeat (2) @(negedge clk);
    #2;
    chk_reset_state();
    rst = 1'b0;
    @(negedge clk);

    // 1: constant frame, sink always ready
    d0 = done_cnt; o0 = out_cnt;
    load_const(160);
    push_const(160, NOUT, 1'b1);
    send_pixels(IMG_W * IMG_H);
    idle();
    drain();
    chk("t1_out_count", out_cnt - o0, NOUT);
    chk("t1_done_count", done_cnt - d0, 1);

    // 2: impulse at (2,3)
    load_const(0);
    img[2][3] = 16'd1600;
    push_model();
    send_pixels(IMG_W * IMG_H);
    idle();
    drain();

    // 3: constant frame, sink ready about half the time
    rand_rdy = 1'b1;
    load_const(160);
    push_const(160, NOUT, 1'b1);
    send_pixels(IMG_W * IMG_H);
    idle();
    drain();
    rand_rdy = 1'b0;

    // 4: two random frames back to back
    d0 = done_cnt; o0 = out_cnt;
    load_rand();
    push_model();
    send_pixels(IMG_W * IMG_H);
    load_rand();
    push_model();
    send_pixels(IMG_W * IMG_H);
    idle();
    drain();
    chk("t4_out_count", out_cnt - o0, 2 * NOUT);
    chk("t4_done_count", done_cnt - d0, 2);

    // 5: abandon a frame after 20 pixels; the two complete windows in it still emerge first
    load_const(160);
    push_const(160, 2, 1'b0);
    send_pixels(20);
    idle();
    drain();
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk_reset_state();
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt; o0 = out_cnt;
    push_const(160, NOUT, 1'b1);
    send_pixels(IMG_W * IMG_H);
    idle();
    drain();
    chk("t5_out_count", out_cnt - o0, NOUT);
    chk("t5_done_count", done_cnt - d0, 1);

    // 6: constant 15 exposes truncation vs rounding
    load_const(15);
    push_const(C15_EXP, NOUT, 1'b1);
    send_pixels(IMG_W * IMG_H);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
